// File: rtl/ook_link_pkg.sv
// Shared definitions for the on-off-keyed serial link (transmitter and receiver).
// Frame: one start symbol, WORD_W data symbols LSB-first, one stop symbol.
package ook_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_SAMPLE_W = 21;
   localparam int DEF_SPS      = 8;
   localparam int DEF_WORD_W   = 8;

   localparam logic START_SYM = 1'b1;
   localparam logic STOP_SYM  = 1'b0;

endpackage

// File: rtl/symbol_integrator.sv
// Integrate-and-dump over one symbol period of SPS accepted samples.
// sum includes the sample being consumed; sym_done marks the last sample of a symbol.
module symbol_integrator
   import ook_link_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int SPS      = DEF_SPS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                sample_en,
   input  logic [SAMPLE_W-1:0]                 sample,
   input  logic                                clear,
   output logic                                sym_done,
   output logic [SAMPLE_W+$clog2(SPS)-1:0]     sum
);

   localparam int CNT_W = $clog2(SPS);
   localparam int ACC_W = SAMPLE_W + CNT_W;

   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last_sample;

   assign last_sample = (cnt_q == CNT_W'(SPS - 1));
   assign sum         = acc_q + ACC_W'(sample);
   assign sym_done    = sample_en && !clear && last_sample;

   // The dump happens on the last sample so the next symbol starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (sample_en) begin
         if (last_sample) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ook_symbol_receiver.sv
// OOK demodulator: integrates each symbol, slices against half the expected "1" energy,
// frames start/data/stop and reports each word or a framing error.
module ook_symbol_receiver
   import ook_link_pkg::*;
#(
   parameter int SAMPLE_W  = DEF_SAMPLE_W,
   parameter int SPS       = DEF_SPS,
   parameter int WORD_W    = DEF_WORD_W,
   parameter int REF_SHIFT = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_en,
   input  logic [SAMPLE_W-1:0] rx_sample,
   input  logic [4:0]          atten_ref,
   output logic [WORD_W-1:0]   rx_data,
   output logic                rx_valid,
   output logic                frame_err,
   output logic                busy,
   output state_t              state_dbg
);

   localparam int LOG_SPS = $clog2(SPS);
   localparam int ACC_W   = SAMPLE_W + LOG_SPS;
   localparam int REF_W   = 5 + REF_SHIFT;
   localparam int CMP_W   = ACC_W + REF_W + 1;
   localparam int BIT_W   = $clog2(WORD_W + 1);

   state_t            state_q, state_n;
   logic [4:0]        ref_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [WORD_W-1:0] shreg_q;
   logic              start_hit, start_evt, clear, decision, sym_done;
   logic [ACC_W-1:0]  sum;
   logic [CMP_W-1:0]  ref_level_in, sum_thr;

   // Start detection uses the live atten_ref; the frame slices with the latched copy.
   assign ref_level_in = CMP_W'(atten_ref) << REF_SHIFT;
   assign start_hit    = (CMP_W'(rx_sample) << 1) >= ref_level_in;
   assign sum_thr      = ((CMP_W'(ref_q) << REF_SHIFT) << LOG_SPS) >> 1;
   assign decision     = CMP_W'(sum) >= sum_thr;
   assign clear        = (state_q == IDLE) && !start_evt;
   assign state_dbg    = state_q;

   symbol_integrator #(
      .SAMPLE_W (SAMPLE_W),
      .SPS      (SPS)
   ) u_integrator (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .sample    (rx_sample),
      .clear     (clear),
      .sym_done  (sym_done),
      .sum       (sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_n;
   end

   always_comb begin
      state_n   = state_q;
      start_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_en && start_hit) begin
               state_n   = START;
               start_evt = 1'b1;
            end
         end
         START: if (sym_done) state_n = (decision == START_SYM) ? DATA : IDLE;
         DATA:  if (sym_done && (bit_cnt_q == BIT_W'(WORD_W - 1))) state_n = STOP;
         STOP:  if (sym_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // rx_valid is a one-cycle pulse with no ready: the consumer must capture rx_data
   // on that cycle; rx_data stays stable until the next rx_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= (state_n != IDLE);
         if (start_evt) ref_q <= atten_ref;
         if (sym_done) begin
            case (state_q)
               START: bit_cnt_q <= '0;
               DATA: begin
                  shreg_q   <= {decision, shreg_q[WORD_W-1:1]};
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end
               STOP: begin
                  if (decision == STOP_SYM) begin
                     rx_valid <= 1'b1;
                     rx_data  <= shreg_q;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/ook_symbol_receiver.md
# ook_symbol_receiver

Receive-side demodulator for the on-off-keyed serial link; it sits directly after the channel model. It takes the attenuated, noisy sample stream plus the attenuated reference amplitude, integrates each symbol period, and slices the sum against a threshold derived from that amplitude. It then frames symbols (start, WORD_W data LSB-first, stop) and emits each recovered word with a one-cycle valid pulse, or flags a framing error.

## Interface
- SAMPLE_W, 21: width of received sample (unsigned).
- SPS, 8: samples per symbol; power of two, ≥2.
- WORD_W, 8: data symbols per frame.
- REF_SHIFT, 0: left shift applied to atten_ref to express it in sample LSBs.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- sample_en  in  1  qualifies rx_sample; only cycles with sample_en=1 are consumed.
- rx_sample  in  SAMPLE_W  received sample.
- atten_ref  in  5  attenuated amplitude of a "1" symbol (before REF_SHIFT).
- rx_data  out  WORD_W  last good word; holds until next good frame.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- frame_err  out  1  one-cycle pulse: stop symbol read as 1.
- busy  out  1  high in every state except IDLE.

## Operation
- Line idles low. Start symbol = 1, data symbols LSB-first, stop symbol = 0.
- ref_level = atten_ref << REF_SHIFT. sum_thr = (ref_level * SPS) >> 1.
- Accumulator width: SAMPLE_W + log2(SPS), unsigned, no saturation needed.
- States:
  - IDLE → START when sample_en and 2*rx_sample ≥ ref_level. That sample is sample 0 of the start symbol. atten_ref is latched at this transition and is used for the whole frame.
  - START: after SPS samples, go to DATA if sum ≥ sum_thr, else go to IDLE with no output (false start).
  - DATA: after each SPS samples, shift the decision (sum ≥ sum_thr → 1) into the shift register at MSB, shifting right. After WORD_W symbols, go to STOP.
  - STOP: after SPS samples, a decision of 0 loads rx_data and pulses rx_valid; a decision of 1 pulses frame_err and leaves rx_data unchanged. Either way go to IDLE.
- Accumulator and sample counter clear at each symbol boundary. The first sample of the next symbol adds to 0.
- In the sample cycle that transitions STOP→IDLE, start detection is not evaluated. Detection resumes on the next sample_en.
- sample_en=0 freezes the accumulator, counters and state. Gaps of any length are legal.
- A sum equal to sum_thr decides 1.
- atten_ref=0 gives ref_level=0. Any sample then triggers START and every symbol decides 1, so frames end in frame_err. This is legal, not guarded.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state IDLE, accumulator/counters/shift register 0.
- Reset asserted mid-frame aborts immediately with no pulse. Decoding restarts from IDLE after release.
- All outputs are registered.
- rx_valid/frame_err assert the cycle after the clock edge that consumes the final stop sample. They last exactly one cycle.
- rx_data changes in the same cycle rx_valid rises.
- busy rises the cycle after the start-detect sample and falls with the pulse.
- Frame length is (WORD_W+2)*SPS accepted samples; with defaults that is 80.
- No backpressure. Downstream must take rx_data on rx_valid. It is stable until the next rx_valid.

## Structure
- Shared package ook_link_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - default SAMPLE_W/SPS/WORD_W;
  - the start=1/stop=0 symbol constants, which the transmitter also uses.
- Sub-module symbol_integrator (integrate-and-dump): accumulator, sample counter, sym_done strobe, sum output, clear input.
- The FSM, threshold compare, shift register and output registers stay in the top module.

## Test plan
Defaults throughout; atten_ref=8 unless stated, so ref_level=8 and sum_thr=32; "1"=8, "0"=0 per sample unless stated.
- Clean frame 0xA5, sample_en=1 continuously: rx_data=0xA5, rx_valid pulse exactly 1 cycle after the 80th sample; frame_err stays 0.
- Same frame with the channel's 0..7 counting noise added to every sample: 0xA5 decoded. A noise-only idle line (symbol sum 28 < 32) produces only false starts and no pulses.
- False start: one sample of 5, then zeros. busy is high for 8 samples, then IDLE; no rx_valid/frame_err; the following 0x3C frame decodes.
- Stop symbol sent as 1 after data 0x0F: frame_err pulses, rx_valid stays 0, rx_data keeps its prior value.
- Threshold boundary: data bit0 symbol sum exactly 32 → bit 1; bit1 sum 31 → bit 0.
- sample_en alternating 1/0 across frame 0x5A, with reset pulsed after sample 40 of a prior frame:
  - the aborted frame yields no output and all outputs are 0;
  - the next frame gives 0x5A, with rx_valid 1 cycle after its 80th accepted sample.
